// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into 32-bit words behind a 2-entry FIFO; optional imm range checks via INSTR_ENC_RANGE_CHECK_EN
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);
  logic [31:0] enc;
  logic fmt_bad, rng_err, err, push, pop, wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [32:0] mem [2];

  // field packing per instruction format; illegal formats encode as zero
  always_comb begin
    enc = '0;
    case (fmt)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc = {imm[31:12], rd, opcode};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc = '0;
    endcase
  end

  assign fmt_bad = fmt > 3'd5;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = $signed(imm);
  // immediate range and alignment checks; the word is still packed from truncated bits
  always_comb begin
    rng_err = 1'b0;
    case (fmt)
      3'd1, 3'd2: rng_err = simm < -32'sd2048 || simm > 32'sd2047;
      3'd3: rng_err = simm < -32'sd4096 || simm > 32'sd4094 || imm[0];
      3'd4: rng_err = imm[11:0] != 12'd0;
      3'd5: rng_err = simm < -32'sd1048576 || simm > 32'sd1048574 || imm[0];
      default: rng_err = 1'b0;
    endcase
  end
`else
  assign rng_err = 1'b0;
`endif

  assign err = fmt_bad | rng_err;
  assign in_ready = !cnt[1] && !clear;
  assign out_valid = cnt != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {out_err, out_instr} = out_valid ? mem[rd_ptr] : 33'd0;
  assign out_addr = addr;

  // payload storage; reads are masked by out_valid so no reset is needed
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {err, enc};

  // FIFO pointers, occupancy, word address and saturating error count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
      addr <= BASE_ADDR;
      err_cnt <= 8'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
      addr <= BASE_ADDR;
      err_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop) begin
        rd_ptr <= !rd_ptr;
        addr <= addr + ADDR_W'(1);
        if (out_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized + directed checks of instr_encoder against a behavioural model
module tb_instr_encoder;
  localparam int AW = 2;
  localparam logic [AW-1:0] BASE = 2'd3;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0, rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] fmt, funct3;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, out_instr;
  logic [AW-1:0] out_addr;
  logic [7:0] err_cnt;

  int n_cmp = 0, n_bad = 0;
  logic [32:0] q[$];
  logic [AW-1:0] m_addr;
  int m_ecnt;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // reference encoding built from field positions with shifts and masks; returns {err, word}
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] b, dv, s2v, w;
    bit e;
    longint v;
    v = longint'($signed(im));
    b = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
    dv = 32'(d) << 7;
    s2v = 32'(s2) << 20;
    e = 1'b0;
    case (f)
      3'd0: w = b | dv | s2v | (32'(f7) << 25);
      3'd1: begin w = b | dv | ((im & 32'hfff) << 20); e = v < -2048 || v > 2047; end
      3'd2: begin
        w = b | s2v | ((im & 32'h1f) << 7) | (((im >> 5) & 32'h7f) << 25);
        e = v < -2048 || v > 2047;
      end
      3'd3: begin
        w = b | s2v | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 32'h1) << 7)
              | (((im >> 5) & 32'h3f) << 25) | (((im >> 12) & 32'h1) << 31);
        e = v < -4096 || v > 4094 || im[0];
      end
      3'd4: begin w = 32'(op) | dv | (im & 32'hfffff000); e = (im & 32'hfff) != 0; end
      3'd5: begin
        w = 32'(op) | dv | (((im >> 12) & 32'hff) << 12) | (((im >> 11) & 32'h1) << 20)
              | (((im >> 1) & 32'h3ff) << 21) | (((im >> 20) & 32'h1) << 31);
        e = v < -1048576 || v > 1048574 || im[0];
      end
      default: return {1'b1, 32'h0};
    endcase
    return {RC && e, w};
  endfunction

  // scoreboard: predicts the state the DUT reaches at the coming rising edge
  initial begin : model_proc
    bit pu;
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        q.delete();
        m_addr = BASE;
        m_ecnt = 0;
      end else begin
        pu = in_valid && q.size() < 2;
        if (q.size() != 0 && out_ready) begin
          if (q[0][32] && m_ecnt < 255) m_ecnt++;
          void'(q.pop_front());
          m_addr++;
        end
        if (pu) q.push_back(ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic rand_r();
    set_req(3'd0, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), $urandom);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, out_instr, out_err, out_addr, err_cnt, in_ready} !== {1'b0, 32'h0, 1'b0, BASE, 8'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state got v=%b i=%h e=%b a=%0d c=%0d r=%b want v=0 i=0 e=0 a=%0d c=0 r=1",
               out_valid, out_instr, out_err, out_addr, err_cnt, in_ready, BASE);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ew [4] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h001000EF};
    logic [AW-1:0] ea [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        1: set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        2: set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        default: set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      endcase
      tick();
      n_cmp++;
      if ({out_valid, out_instr, out_err, out_addr} !== {1'b1, ew[i], 1'b0, ea[i]}) begin
        n_bad++;
        $display("FAIL basic_%0d got v=%b i=%h e=%b a=%0d want v=1 i=%h e=0 a=%0d",
                 i, out_valid, out_instr, out_err, out_addr, ew[i], ea[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, out_addr} !== {1'b0, 2'd3}) begin
      n_bad++;
      $display("FAIL basic_drain got v=%b a=%0d want v=0 a=3", out_valid, out_addr);
    end
  endtask

  task automatic test_err();
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_instr, out_err} !== {32'h80000093, RC}) begin
      n_bad++;
      $display("FAIL err_imm2048 got i=%h e=%b want i=80000093 e=%b", out_instr, out_err, RC);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (err_cnt !== 8'(RC)) begin
      n_bad++;
      $display("FAIL err_cnt1 got %0d want %0d", err_cnt, RC);
    end
    out_ready = 1'b0;
    set_req(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_instr, out_err} !== {1'b1, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL err_fmt7 got v=%b i=%h e=%b want v=1 i=0 e=1", out_valid, out_instr, out_err);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (err_cnt !== 8'(RC) + 8'd1) begin
      n_bad++;
      $display("FAIL err_cnt2 got %0d want %0d", err_cnt, 8'(RC) + 8'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] e [3];
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_r();
      e[i] = ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
      tick();
      n_cmp++;
      if ({out_valid, out_err, out_instr, in_ready} !== {1'b1, e[0], i == 0}) begin
        n_bad++;
        $display("FAIL bp_fill_%0d got v=%b ei=%h r=%b want v=1 ei=%h r=%b",
                 i, out_valid, {out_err, out_instr}, in_ready, e[0], i == 0);
      end
    end
    tick();
    n_cmp++;
    if ({out_valid, out_err, out_instr, in_ready} !== {1'b1, e[0], 1'b0}) begin
      n_bad++;
      $display("FAIL bp_hold got v=%b ei=%h r=%b want v=1 ei=%h r=0", out_valid, {out_err, out_instr}, in_ready, e[0]);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, out_err, out_instr, in_ready, out_addr} !== {1'b1, e[1], 1'b1, m_addr}) begin
      n_bad++;
      $display("FAIL bp_pop1 got v=%b ei=%h r=%b a=%0d want v=1 ei=%h r=1 a=%0d",
               out_valid, {out_err, out_instr}, in_ready, out_addr, e[1], m_addr);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_err, out_instr} !== {1'b1, e[2]}) begin
      n_bad++;
      $display("FAIL bp_pop2 got v=%b ei=%h want v=1 ei=%h", out_valid, {out_err, out_instr}, e[2]);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_addr_clear();
    logic [AW-1:0] ea [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    clear = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_ready got %b want 0", in_ready);
    end
    tick();
    clear = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_r();
      tick();
      n_cmp++;
      if ({out_valid, out_addr} !== {1'b1, ea[i]}) begin
        n_bad++;
        $display("FAIL wrap_%0d got v=%b a=%0d want v=1 a=%0d", i, out_valid, out_addr, ea[i]);
      end
    end
    set_req(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (err_cnt !== 8'(m_ecnt) || m_ecnt == 0) begin
      n_bad++;
      $display("FAIL clr_precnt got %0d want %0d (nonzero)", err_cnt, m_ecnt);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_r();
    tick();
    tick();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL clr_full got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    end
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_addr, err_cnt} !== {1'b0, BASE, 8'h0}) begin
      n_bad++;
      $display("FAIL clr_flush got v=%b a=%0d c=%0d want v=0 a=%0d c=0", out_valid, out_addr, err_cnt, BASE);
    end
  endtask

  task automatic test_random();
    int bt [16] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 4093,
                    -1048577, -1048576, 1048574, 1048575, 1048576, 0};
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 39) == 0;
      set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), $urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'(bt[$urandom_range(0, 15)]);
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hfffff000;
        default: imm = $urandom;
      endcase
      tick();
      n_cmp++;
      if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2 && !clear}) begin
        n_bad++;
        $display("FAIL rnd_hs_%0d got v=%b r=%b want v=%b r=%b", i, out_valid, in_ready, q.size() != 0, q.size() < 2 && !clear);
      end
      n_cmp++;
      if ({out_addr, err_cnt} !== {m_addr, 8'(m_ecnt)}) begin
        n_bad++;
        $display("FAIL rnd_cnt_%0d got a=%0d c=%0d want a=%0d c=%0d", i, out_addr, err_cnt, m_addr, m_ecnt);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if ({out_err, out_instr} !== q[0]) begin
          n_bad++;
          $display("FAIL rnd_data_%0d got %h want %h", i, {out_err, out_instr}, q[0]);
        end
      end
    end
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_r();
    tick();
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_instr, out_err, out_addr, err_cnt} !== {1'b0, 32'h0, 1'b0, BASE, 8'h0}) begin
      n_bad++;
      $display("FAIL arst_now got v=%b i=%h e=%b a=%0d c=%0d want v=0 i=0 e=0 a=%0d c=0",
               out_valid, out_instr, out_err, out_addr, err_cnt, BASE);
    end
    #13;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_instr, out_err, out_addr, err_cnt, in_ready} !== {1'b0, 32'h0, 1'b0, BASE, 8'h0, 1'b1}) begin
        n_bad++;
        $display("FAIL arst_hold_%0d got v=%b i=%h e=%b a=%0d c=%0d r=%b", i, out_valid, out_instr, out_err, out_addr, err_cnt, in_ready);
      end
    end
    rand_r();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_err, out_instr, out_addr} !== {1'b1, ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm), BASE}) begin
      n_bad++;
      $display("FAIL arst_first got v=%b ei=%h a=%0d", out_valid, {out_err, out_instr}, out_addr);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_err();
    test_backpressure();
    test_addr_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded RISC-V RV32I instruction fields (format, opcode, registers, functs, signed immediate) into a 32-bit instruction word. It is the inverse of the core's immediate/field decode path and is used by the test loader and boot-ROM builder to stream encoded words into instruction memory. Accepted requests pass through a 2-entry output FIFO with valid/ready on both sides. Each emitted word is tagged with a sequential word address.

## Interface
Parameters:
- `ADDR_W`, 10: width of the word address counter.
- `BASE_ADDR`, 0: word address loaded on reset and on `clear`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous flush of the FIFO, address counter and error counter.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `fmt`  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6–7 illegal.
- `opcode`  in  7  instr[6:0].
- `rd`, `rs1`, `rs2`  in  5 each  register fields.
- `funct3`  in  3; `funct7`  in  7.
- `imm`  in  32  signed immediate: byte offset for B/J, full value for U.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry when `out_valid && out_ready`.
- `out_instr`  out  32  encoded word at the FIFO head.
- `out_addr`  out  ADDR_W  word address of the head entry.
- `out_err`  out  1  the head entry failed an encoding check.
- `err_cnt`  out  8  saturating count of popped entries with `out_err=1`.

## Operation
- Packing, with unused fields ignored:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Illegal `fmt` (6 or 7): instruction is 32'h0000_0000 and `err=1`. This applies whether or not range checking is compiled in.
- Error checks are combinational on the input. The result (instruction plus err) is written into the FIFO on accept.
- FIFO:
  - Depth 2.
  - `in_ready = !full && !clear`.
  - Push on accept, pop on output handshake.
  - Push and pop in the same cycle with 1 entry leaves the count at 1.
  - In-order delivery.
- Address counter:
  - Starts at `BASE_ADDR`.
  - Increments by 1 on each pop.
  - Wraps modulo 2^ADDR_W.
  - `out_addr` equals the counter value.
- `err_cnt` increments on a pop with err=1 and saturates at 255.
- `clear` has priority over push and pop in its cycle:
  - empties the FIFO;
  - sets the counter to `BASE_ADDR`;
  - sets `err_cnt` to 0.

## Timing
- Reset values:
  - `out_valid=0`
  - `out_instr=0`
  - `out_err=0`
  - `out_addr=BASE_ADDR`
  - `err_cnt=0`
  - `in_ready=1` once `rst_n` is high and `clear=0`.
- Latency: an accept in cycle N appears on `out_*` in cycle N+1 when the FIFO was empty.
- Throughput: 1 word per cycle while `out_ready=1`.
- `out_instr`, `out_err` and `out_valid` are held stable while `out_valid && !out_ready`.
- Reset asserted mid-stream discards all entries immediately. No partial output follows deassertion.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined, `err=1` when any of these holds:
  - I/S: `imm` is outside [-2048, 2047].
  - B: `imm` is outside [-4096, 4094], or `imm[0]` != 0.
  - J: `imm` is outside [-1048576, 1048574], or `imm[0]` != 0.
  - U: `imm[11:0]` != 0.
  - In all these cases the instruction is still packed from the truncated bits.
- Not defined: only illegal `fmt` sets err. All other formats report `err=0`.

## Test plan
- I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> `out_instr`=0x00500093, `out_addr`=BASE_ADDR, `out_err`=0, one cycle after accept.
- S sw (0x23, funct3=2, rs1=1, rs2=2, imm=8) -> 0x0020A423. Then B beq (0x63, rs1=rs2=0, imm=-4) -> 0xFE000EE3. Then J jal (0x6F, rd=1, imm=2048) -> 0x001000EF. Addresses are consecutive.
- I with imm=2048 -> 0x80000093 and `out_err=1`, `err_cnt`=1 with the macro defined. Without the macro, `out_err=0`. `fmt=7` -> 0x00000000 and `out_err=1` in both builds.
- `out_ready=0` while pushing 3 requests:
  - the first two are accepted;
  - `in_ready=0` on the third;
  - raising `out_ready` drains in order, and the third is accepted the cycle after the first pop.
- ADDR_W=2, BASE_ADDR=3: five pops give `out_addr` 3, 0, 1, 2, 3. Assert `clear` with 2 entries queued: next cycle `out_valid=0`, `out_addr`=3, `err_cnt`=0.
- Drop `rst_n` with 2 entries queued, asynchronous to `clk`: `out_valid` goes to 0 immediately and all reset values hold until the next accept.
